// File: rtl/io_cond_pkg.sv
// Shared types and defaults for the pushbutton/switch input conditioning front end.
package io_cond_pkg;

  localparam int unsigned DEBOUNCE_DEFAULT = 500000;

  typedef enum logic [1:0] {
    UP,
    WAIT_DOWN,
    DOWN,
    WAIT_UP
  } key_state_t;

endpackage

// File: rtl/key_debounce.sv
// One pushbutton: 2-flop synchronizer, debounce FSM with stability counter,
// registered active-low level and a one-cycle press pulse.
module key_debounce
  import io_cond_pkg::*;
#(
  parameter int unsigned DebounceCycles = DEBOUNCE_DEFAULT
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic key_raw_ni,
  output logic key_no,
  output logic key_press_o
);

  localparam int unsigned CntW = $clog2(DebounceCycles);
  localparam logic [CntW-1:0] CntMax = CntW'(DebounceCycles - 1);

  logic            s1_q, s2_q;
  key_state_t      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            key_n_q, key_n_d;
  logic            press_q, press_d;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      s1_q    <= 1'b1;
      s2_q    <= 1'b1;
      state_q <= UP;
      cnt_q   <= '0;
      key_n_q <= 1'b1;
      press_q <= 1'b0;
    end else begin
      s1_q    <= key_raw_ni;
      s2_q    <= s1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      key_n_q <= key_n_d;
      press_q <= press_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      UP: begin
        if (!s2_q) begin
          state_d = WAIT_DOWN;
          cnt_d   = '0;
        end
      end
      WAIT_DOWN: begin
        if (s2_q) begin
          state_d = UP;
        end else if (cnt_q == CntMax) begin
          state_d = DOWN;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      DOWN: begin
        if (s2_q) begin
          state_d = WAIT_UP;
          cnt_d   = '0;
        end
      end
      WAIT_UP: begin
        if (!s2_q) begin
          state_d = DOWN;
        end else if (cnt_q == CntMax) begin
          state_d = UP;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = UP;
    endcase
  end

  // Outputs are registered from the next state so they carry no input-to-output path.
  always_comb begin
    key_n_d = !((state_d == DOWN) || (state_d == WAIT_UP));
    press_d = (state_q == WAIT_DOWN) && (state_d == DOWN);
  end

  assign key_no      = key_n_q;
  assign key_press_o = press_q;

endmodule

// File: rtl/button_conditioner.sv
// Conditions raw pushbuttons and slide switches: per-key debounce instances plus
// a whole-vector switch debouncer sharing one stability counter.
module button_conditioner
  import io_cond_pkg::*;
#(
  parameter int unsigned N_KEYS          = 3,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int unsigned SW_WIDTH        = 16
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic [N_KEYS-1:0]   Key_raw_n,
  input  logic [SW_WIDTH-1:0] SW_raw,
  output logic [N_KEYS-1:0]   Key_n,
  output logic [N_KEYS-1:0]   Key_press,
  output logic [SW_WIDTH-1:0] SW
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  for (genvar k = 0; k < N_KEYS; k++) begin : g_key
    key_debounce #(
      .DebounceCycles(DEBOUNCE_CYCLES)
    ) u_key_debounce (
      .clk_i      (Clk),
      .reset_i    (Reset),
      .key_raw_ni (Key_raw_n[k]),
      .key_no     (Key_n[k]),
      .key_press_o(Key_press[k])
    );
  end

  logic [SW_WIDTH-1:0] sw_s1_q, sw_s2_q;
  logic [SW_WIDTH-1:0] sw_last_q, sw_last_d;
  logic [CntW-1:0]     sw_cnt_q, sw_cnt_d;
  logic [SW_WIDTH-1:0] sw_q, sw_d;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      sw_s1_q   <= '0;
      sw_s2_q   <= '0;
      sw_last_q <= '0;
      sw_cnt_q  <= '0;
      sw_q      <= '0;
    end else begin
      sw_s1_q   <= SW_raw;
      sw_s2_q   <= sw_s1_q;
      sw_last_q <= sw_last_d;
      sw_cnt_q  <= sw_cnt_d;
      sw_q      <= sw_d;
    end
  end

  // Any change restarts the window; once stable the counter saturates and SW tracks sw_last.
  always_comb begin
    sw_last_d = sw_last_q;
    sw_cnt_d  = sw_cnt_q;
    sw_d      = sw_q;
    if (sw_s2_q != sw_last_q) begin
      sw_last_d = sw_s2_q;
      sw_cnt_d  = '0;
    end else if (sw_cnt_q == CntMax) begin
      sw_d = sw_last_q;
    end else begin
      sw_cnt_d = sw_cnt_q + CntW'(1);
    end
  end

  assign SW = sw_q;

endmodule

// File: doc/button_conditioner.md
# button_conditioner

Front-end conditioning stage between the board's raw pushbuttons/slide switches and the SLC-3 top level. Synchronizes each asynchronous input to `Clk`, rejects contact bounce with a per-input stability counter, and presents clean active-low button levels (same polarity the SLC-3 top expects on `Run`/`Continue`/`Reset`), one-cycle press pulses, and a debounced 16-bit switch word for `S`.

## Interface
- `N_KEYS`, default 3: number of pushbuttons.
- `DEBOUNCE_CYCLES`, default 500000: required stable cycles, 10 ms at 50 MHz; must be ≥ 2.
- `SW_WIDTH`, default 16: switch vector width.

- `Clk`  in  1  single system clock; all logic on rising edge.
- `Reset`  in  1  synchronous, active-high, from power-on reset logic (not from a key).
- `Key_raw_n`  in  N_KEYS  raw active-low buttons, asynchronous.
- `SW_raw`  in  SW_WIDTH  raw slide switches, asynchronous.
- `Key_n`  out  N_KEYS  debounced active-low button level.
- `Key_press`  out  N_KEYS  one-cycle active-high pulse per debounced press.
- `SW`  out  SW_WIDTH  debounced switch word.

## Operation
- Every raw bit passes through a 2-flop synchronizer (`s1`, `s2`); only `s2` is used downstream.
- Per key FSM, counter `cnt` of width $clog2(DEBOUNCE_CYCLES):
  - `UP`: `s2`=0 → `WAIT_DOWN`, `cnt`←0.
  - `WAIT_DOWN`: `s2`=1 → `UP` (bounce, no pulse); else if `cnt`=DEBOUNCE_CYCLES−1 → `DOWN`, `Key_press`←1; else `cnt`++.
  - `DOWN`: `s2`=1 → `WAIT_UP`, `cnt`←0.
  - `WAIT_UP`: `s2`=0 → `DOWN`; else if `cnt`=DEBOUNCE_CYCLES−1 → `UP`; else `cnt`++.
  - `Key_n`=0 in `DOWN` and `WAIT_UP`, 1 in `UP` and `WAIT_DOWN`; registered from next state.
  - `Key_press` high for exactly one cycle per `WAIT_DOWN`→`DOWN` transition; no pulse on release.
- Switches (whole vector, shared counter): register `sw_last`.
  - `s2`≠`sw_last`: `sw_last`←`s2`, `cnt`←0.
  - else if `cnt`=DEBOUNCE_CYCLES−1: `SW`←`sw_last`, `cnt` holds (saturates).
  - else `cnt`++.
- Keys are independent; simultaneous presses on several keys produce simultaneous pulses.
- Reset values: `Key_n` all 1, `Key_press` all 0, `SW` 0; key synchronizers 1, switch synchronizers 0; FSMs `UP`; counters 0.
- `Reset` mid-debounce aborts it: no pulse in or after the reset cycle. A key still held after `Reset` deasserts is re-debounced and produces one press pulse.

## Timing
- Raw key low set up before edge E and held: `Key_n` falls and `Key_press` rises after edge E+DEBOUNCE_CYCLES+2. `Key_press` falls after the next edge.
- Release latency is identical: `Key_n` rises after edge E+DEBOUNCE_CYCLES+2.
- Switch change stable from edge E: `SW` updates after edge E+DEBOUNCE_CYCLES+2.
- Any input glitch shorter than DEBOUNCE_CYCLES synchronized cycles leaves the outputs unchanged.
- No combinational path from input to output.

## Structure
- Package `io_cond_pkg`: `key_state_t` enum (`UP`, `WAIT_DOWN`, `DOWN`, `WAIT_UP`) and `DEBOUNCE_DEFAULT` = 500000.
- Sub-module `key_debounce`: synchronizer, FSM and counter for one key. Instantiated N_KEYS times via generate.
- Switch path lives in the top of `button_conditioner`.

## Test plan
Bench uses DEBOUNCE_CYCLES=4.
- Reset: assert `Reset` 2 cycles with all keys released → `Key_n`=3'b111, `Key_press`=0, `SW`=16'h0000.
- Clean press: `Key_raw_n[1]` low before edge E and held → `Key_n[1]`=0 and `Key_press[1]`=1 only after edge E+6. `Key_press[1]` is 0 after E+7. Release gives `Key_n[1]`=1 six edges later with no pulse.
- Bounce: key 0 toggles low 2 cycles / high 1 cycle ×5, then stays low → exactly one `Key_press[0]` pulse, 6 edges after the final low edge.
- Switches: `SW_raw`=16'h3A5C stable from edge E → `SW`=16'h3A5C after edge E+6. A 3-cycle glitch to 16'hFFFF → `SW` unchanged.
- Simultaneous: keys 0 and 2 pressed at the same edge → both pulses in the same cycle. Key 1 is unaffected.
- Reset mid-debounce: press key 2, assert `Reset` at edge E+4 for 1 cycle while the key is held → no pulse before reset. After reset releases, one pulse 6 edges after the first post-reset sampling edge.
